// File: rtl/dmux4_lane_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmux4_lane_deser_pkg
// Description : Shared constants and types for the four-lane deserializer.
//               NUM_LANES   - number of demux lanes (a, b, c, d)
//               DEFAULT_W   - default word width per lane
//               lane_id_t   - 2-bit lane number (0=a .. 3=d)
//               next_lane() - round-robin successor with wrap 3 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
package dmux4_lane_deser_pkg;

    localparam int NUM_LANES = 4;
    localparam int DEFAULT_W = 8;

    typedef logic [1:0] lane_id_t;

    // Two-bit addition wraps naturally from lane 3 back to lane 0.
    function automatic lane_id_t next_lane(input lane_id_t lane);
        return lane + 2'd1;
    endfunction

endpackage : dmux4_lane_deser_pkg
`default_nettype wire

// File: rtl/dmux4_lane_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : dmux4_lane_deser_if
// Description : Bundle between the demux/downstream side and the deserializer.
//               Input side : in_valid, in_sel, a, b, c, d
//               Output side: out_valid, out_ready, out_data, out_lane
//               Status     : ovf (sticky per-lane overflow), ovf_clr
//               Modports   : master = environment, slave = deserializer
// Revision    : 1.0 - initial release
// ============================================================================
interface dmux4_lane_deser_if
    import dmux4_lane_deser_pkg::*;
#(
    parameter int W = DEFAULT_W
);

    logic                 in_valid;
    lane_id_t             in_sel;
    logic                 a;
    logic                 b;
    logic                 c;
    logic                 d;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    lane_id_t             out_lane;
    logic [NUM_LANES-1:0] ovf;
    logic                 ovf_clr;

    modport master (
        output in_valid, in_sel, a, b, c, d, out_ready, ovf_clr,
        input  out_valid, out_data, out_lane, ovf
    );

    modport slave (
        input  in_valid, in_sel, a, b, c, d, out_ready, ovf_clr,
        output out_valid, out_data, out_lane, ovf
    );

endinterface : dmux4_lane_deser_if
`default_nettype wire

// File: rtl/dmux4_lane_shifter.sv
`default_nettype none
// ============================================================================
// Module      : dmux4_lane_shifter
// Description : One lane's word accumulator: W-bit MSB-first shift register,
//               bit counter (0..W) and full flag.
//               clk, rst_n - clock, asynchronous active-low reset
//               bit_in     - serial bit
//               bit_en     - accept bit_in this cycle
//               clear      - word handed off; restart the lane
//               word       - accumulated word (first bit ends up at MSB)
//               full       - W bits collected, waiting for hand-off
// Revision    : 1.0 - initial release
// ============================================================================
module dmux4_lane_shifter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         bit_in,
    input  wire logic         bit_en,
    input  wire logic         clear,
    output logic [W-1:0]      word,
    output logic              full
);

    localparam int            CW         = $clog2(W + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(W - 1);

    logic [W-1:0]  r_sr_q,   w_sr_d,   w_sr_base;
    logic [CW-1:0] r_cnt_q,  w_cnt_d,  w_cnt_base;
    logic          r_full_q, w_full_d;

    // A clear and a new bit in the same cycle: the bit becomes the first
    // bit of the restarted word, so the shift starts from an empty lane.
    always_comb begin
        w_sr_base  = clear ? '0 : r_sr_q;
        w_cnt_base = clear ? '0 : r_cnt_q;
        w_sr_d     = w_sr_base;
        w_cnt_d    = w_cnt_base;
        w_full_d   = clear ? 1'b0 : r_full_q;
        if (bit_en) begin
            w_sr_d   = {w_sr_base[W-2:0], bit_in};
            w_cnt_d  = w_cnt_base + CW'(1);
            w_full_d = (w_cnt_base == C_CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_q   <= '0;
            r_cnt_q  <= '0;
            r_full_q <= 1'b0;
        end else begin
            r_sr_q   <= w_sr_d;
            r_cnt_q  <= w_cnt_d;
            r_full_q <= w_full_d;
        end
    end

    assign word = r_sr_q;
    assign full = r_full_q;

endmodule : dmux4_lane_shifter
`default_nettype wire

// File: rtl/dmux4_lane_deser.sv
`default_nettype none
// ============================================================================
// Module      : dmux4_lane_deser
// Description : Four-lane serial-to-parallel collector behind a registered
//               1-to-4 demux. Lane decode, round-robin arbiter, single-entry
//               output register and sticky per-lane overflow flags.
//               clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - slave side of dmux4_lane_deser_if (lane bits in,
//                       tagged words out over valid/ready, ovf / ovf_clr)
// Revision    : 1.0 - initial release
// ============================================================================
module dmux4_lane_deser
    import dmux4_lane_deser_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    dmux4_lane_deser_if.slave       bus
);

    logic [NUM_LANES-1:0] w_lane_bits;
    logic                 w_bit_in;
    logic [NUM_LANES-1:0] w_lane_hit;
    logic [NUM_LANES-1:0] w_full;
    logic [W-1:0]         w_word [NUM_LANES];
    logic [NUM_LANES-1:0] w_bit_en;
    logic [NUM_LANES-1:0] w_drop;
    logic [NUM_LANES-1:0] w_grant_oh;
    logic                 w_grant_vld;
    lane_id_t             w_grant_lane;
    logic                 w_out_free;

    logic                 r_out_valid_q, w_out_valid_d;
    logic [W-1:0]         r_out_data_q,  w_out_data_d;
    lane_id_t             r_out_lane_q,  w_out_lane_d;
    lane_id_t             r_rr_ptr_q,    w_rr_ptr_d;
    logic [NUM_LANES-1:0] r_ovf_q,       w_ovf_d;

    // Only the lane named by in_sel carries meaningful data.
    assign w_lane_bits = {bus.d, bus.c, bus.b, bus.a};
    assign w_bit_in    = w_lane_bits[bus.in_sel];

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lanes
            assign w_lane_hit[gi] = bus.in_valid && (bus.in_sel == lane_id_t'(gi));
            // A full lane may still take a bit in the cycle its word leaves.
            assign w_bit_en[gi]   = w_lane_hit[gi] && (!w_full[gi] || w_grant_oh[gi]);
            assign w_drop[gi]     = w_lane_hit[gi] && w_full[gi] && !w_grant_oh[gi];

            dmux4_lane_shifter #(
                .W      (W)
            ) u_shifter (
                .clk    (clk),
                .rst_n  (rst_n),
                .bit_in (w_bit_in),
                .bit_en (w_bit_en[gi]),
                .clear  (w_grant_oh[gi]),
                .word   (w_word[gi]),
                .full   (w_full[gi])
            );
        end
    endgenerate

    assign w_out_free = !r_out_valid_q || bus.out_ready;

    // Round-robin: first full lane at or after rr_ptr, wrapping 3 -> 0.
    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant_lane = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!w_grant_vld && w_full[r_rr_ptr_q + lane_id_t'(k)]) begin
                w_grant_vld  = 1'b1;
                w_grant_lane = r_rr_ptr_q + lane_id_t'(k);
            end
        end
        if (!w_out_free) begin
            w_grant_vld = 1'b0;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            w_grant_oh[i] = w_grant_vld && (w_grant_lane == lane_id_t'(i));
        end
    end

    // Data and lane tag are only rewritten on a grant, so they stay stable
    // while a word waits for out_ready.
    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_out_data_d  = r_out_data_q;
        w_out_lane_d  = r_out_lane_q;
        w_rr_ptr_d    = r_rr_ptr_q;
        if (w_out_free) begin
            w_out_valid_d = w_grant_vld;
            if (w_grant_vld) begin
                w_out_data_d = w_word[w_grant_lane];
                w_out_lane_d = w_grant_lane;
                w_rr_ptr_d   = next_lane(w_grant_lane);
            end
        end
        // A new drop takes priority over a simultaneous clear.
        w_ovf_d = (bus.ovf_clr ? '0 : r_ovf_q) | w_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
            r_out_lane_q  <= '0;
            r_rr_ptr_q    <= '0;
            r_ovf_q       <= '0;
        end else begin
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
            r_out_lane_q  <= w_out_lane_d;
            r_rr_ptr_q    <= w_rr_ptr_d;
            r_ovf_q       <= w_ovf_d;
        end
    end

    assign bus.out_valid = r_out_valid_q;
    assign bus.out_data  = r_out_data_q;
    assign bus.out_lane  = r_out_lane_q;
    assign bus.ovf       = r_ovf_q;

endmodule : dmux4_lane_deser
`default_nettype wire

// File: tb/tb_dmux4_lane_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux4_lane_deser
// Description : Directed self-checking bench for dmux4_lane_deser (W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux4_lane_deser;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    dmux4_lane_deser_if #(.W(W)) bus ();

    dmux4_lane_deser #(
        .W     (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input int lane, input logic [7:0] data);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        if (v) begin
            chk({tag, "_lane"}, {30'd0, bus.out_lane}, lane);
            chk({tag, "_data"}, {24'd0, bus.out_data}, {24'd0, data});
        end
    endtask

    // Non-selected lanes carry the inverted bit so a wrong decode shows up.
    task automatic send_bit(input int lane, input logic bv);
        bus.in_valid = 1'b1;
        bus.in_sel   = lane[1:0];
        bus.a        = (lane == 0) ? bv : ~bv;
        bus.b        = (lane == 1) ? bv : ~bv;
        bus.c        = (lane == 2) ? bv : ~bv;
        bus.d        = (lane == 3) ? bv : ~bv;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input int lane, input logic [7:0] wv);
        for (int i = 7; i >= 0; i--) begin
            send_bit(lane, wv[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v69;
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.a         = 1'b0;
        bus.b         = 1'b0;
        bus.c         = 1'b0;
        bus.d         = 1'b0;
        bus.out_ready = 1'b1;
        bus.ovf_clr   = 1'b0;
        tick();
        tick();

        // Reset state
        chk_out("rst", 1'b0, 0, 8'h00);
        chk("rst_data", {24'd0, bus.out_data}, 32'h0);
        chk("rst_lane", {30'd0, bus.out_lane}, 32'h0);
        chk("rst_ovf", {28'd0, bus.ovf}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single word on lane 0
        send_word(0, 8'hB2);
        chk_out("t1_edgeN", 1'b0, 0, 8'h00);
        tick();
        chk_out("t1_word", 1'b1, 0, 8'hB2);
        chk("t1_ovf", {28'd0, bus.ovf}, 32'h0);
        tick();
        chk_out("t1_drain", 1'b0, 0, 8'h00);

        // Interleaved lanes 1 (all ones) and 3 (all zeros); rr_ptr=1
        for (int i = 0; i < 7; i++) begin
            send_bit(1, 1'b1);
            send_bit(3, 1'b0);
        end
        send_bit(1, 1'b1);
        chk_out("t2_pre", 1'b0, 0, 8'h00);
        send_bit(3, 1'b0);
        chk_out("t2_l1", 1'b1, 1, 8'hFF);
        tick();
        chk_out("t2_l3", 1'b1, 3, 8'h00);
        tick();
        chk_out("t2_drain", 1'b0, 0, 8'h00);

        // Back-pressure: fill all lanes, overflow lane 2; rr_ptr=0
        bus.out_ready = 1'b0;
        send_word(0, 8'h11);
        send_word(1, 8'h22);
        send_word(2, 8'h33);
        send_word(3, 8'h44);
        send_bit(2, 1'b1);
        chk("t3_ovf", {28'd0, bus.ovf}, 32'h4);
        chk_out("t3_hold", 1'b1, 0, 8'h11);
        tick();
        chk_out("t3_stable", 1'b1, 0, 8'h11);
        bus.out_ready = 1'b1;
        tick();
        chk_out("t3_l1", 1'b1, 1, 8'h22);
        tick();
        chk_out("t3_l2", 1'b1, 2, 8'h33);
        tick();
        chk_out("t3_l3", 1'b1, 3, 8'h44);
        tick();
        chk_out("t3_drain", 1'b0, 0, 8'h00);
        chk("t3_ovf_sticky", {28'd0, bus.ovf}, 32'h4);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("t3_ovf_clr", {28'd0, bus.ovf}, 32'h0);

        // Lanes 0 and 2 full with rr_ptr=1 -> lane 2 first
        bus.out_ready = 1'b0;
        send_word(0, 8'hA5);
        send_word(0, 8'h5A);
        send_word(2, 8'hC3);
        chk_out("t4_hold", 1'b1, 0, 8'hA5);
        bus.ovf_clr = 1'b1;
        send_bit(2, 1'b0);
        bus.ovf_clr = 1'b0;
        chk("t4_set_wins", {28'd0, bus.ovf}, 32'h4);
        bus.out_ready = 1'b1;
        tick();
        chk_out("t4_l2", 1'b1, 2, 8'hC3);
        tick();
        chk_out("t4_l0", 1'b1, 0, 8'h5A);
        tick();
        chk_out("t4_drain", 1'b0, 0, 8'h00);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("t4_ovf_clr", {28'd0, bus.ovf}, 32'h0);

        // Grant and new bit on the same lane in one cycle
        v69 = 8'h69;
        send_word(1, 8'h96);
        send_bit(1, v69[7]);
        chk_out("t5_first", 1'b1, 1, 8'h96);
        chk("t5_ovf0", {28'd0, bus.ovf}, 32'h0);
        for (int i = 6; i >= 0; i--) begin
            send_bit(1, v69[i]);
        end
        chk_out("t5_edgeN", 1'b0, 0, 8'h00);
        tick();
        chk_out("t5_second", 1'b1, 1, 8'h69);
        chk("t5_ovf1", {28'd0, bus.ovf}, 32'h0);
        tick();

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) begin
            send_bit(0, 1'b1);
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, bus.out_valid}, 32'h0);
        chk("t6_data", {24'd0, bus.out_data}, 32'h0);
        chk("t6_lane", {30'd0, bus.out_lane}, 32'h0);
        chk("t6_ovf", {28'd0, bus.ovf}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_word(0, 8'h3C);
        chk_out("t6_edgeN", 1'b0, 0, 8'h00);
        tick();
        chk_out("t6_clean", 1'b1, 0, 8'h3C);
        tick();
        chk_out("t6_drain", 1'b0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmux4_lane_deser
`default_nettype wire
